traffic_demand_sensor: RTL and testbench
========================================

// Module: traffic_demand_sensor
// PURPOSE
//  Vehicle-demand front end for the two-road traffic light controller. Debounces the raw
//  loop detectors for road A and road B and counts queued vehicles per road. While a
//  road's light is green it retires one queued vehicle per departure interval, and it
//  drives the per-road "hold green" demand signals that the controller FSM reads.
//  It consumes the controller's l_a/l_b light codes and produces its inp_a/inp_b inputs.
// PARAMETERS
//  DEB_LEN        4   consecutive stable cycles needed to accept a detector change (>=1)
//  DEPART_CYCLES  8   green cycles per retired vehicle (>=1)
//  QW             4   queue counter width; QMAX = 2**QW-1
//  MAX_GREEN      64  green-hold limit in cycles (used only with TDS_MAXGREEN_EN)
// PORTS
//  clk    in   1   clock
//  reset  in   1   synchronous, active-high reset
//  det_a  in   1   raw road-A arrival detector (asynchronous, bouncy)
//  det_b  in   1   raw road-B arrival detector
//  l_a    in   2   road-A light code: 0 green, 1 yellow, 2 red, 3 treated as red
//  l_b    in   2   road-B light code, same encoding
//  dem_a  out  1   road-A demand; connects to controller inp_a
//  dem_b  out  1   road-B demand; connects to controller inp_b
//  q_a    out  QW  road-A queued vehicle count
//  q_b    out  QW  road-B queued vehicle count
//  ovf_a  out  1   sticky flag: arrival lost because q_a was at QMAX
//  ovf_b  out  1   sticky flag: arrival lost because q_b was at QMAX
// BEHAVIOUR
//  - Reset: all synchronizer flops, debounced state, counters, q_x, ovf_x = 0, so dem_x = 0.
//    Reset mid-operation discards the queue. A detector held high through reset is
//    counted once, after a full re-debounce.
//  - Each road (x = a, b) has an identical, independent datapath.
//  - Synchronizer: 2-flop, det_x -> s1_x -> s2_x.
//  - Debounce: deb_x with counter dcnt_x. On each edge:
//      - if s2_x == deb_x, then dcnt_x <= 0.
//      - else if dcnt_x == DEB_LEN-1, then deb_x <= s2_x and dcnt_x <= 0.
//      - else dcnt_x++.
//    A stable det_x change is accepted DEB_LEN+2 edges after the first edge that samples it.
//  - Arrival: deb_x 0->1 transition. q_x updates on the same edge on which deb_x is set.
//    A falling transition has no effect.
//  - Departure timer tcnt_x runs only while l_x == 0 and q_x != 0; otherwise it is held at 0.
//    When tcnt_x == DEPART_CYCLES-1, that edge applies a departure and sets tcnt_x <= 0.
//  - Queue update per edge:
//      - arrival only: q_x+1.
//      - departure only: q_x-1.
//      - both: unchanged.
//      - arrival with q_x == QMAX and no departure: q_x holds at QMAX and ovf_x <= 1.
//        ovf_x is cleared only by reset.
//    Underflow is impossible because the timer is stopped at q_x == 0.
//  - l_x values 1, 2 and 3 all stop and clear the timer.
//  - dem_x is combinational from registered state only, never directly from det_x:
//    dem_x = (q_x != 0), modified by the optional feature below.
// CONFIGURATION
//  Macro TDS_MAXGREEN_EN.
//  - Defined: gcnt_x counts consecutive cycles with l_x == 0, saturates at MAX_GREEN, and
//    is cleared when l_x != 0.
//    dem_a = (q_a != 0) && !(gcnt_a == MAX_GREEN && q_b != 0). dem_b is symmetric.
//    The cut fires only when the opposing road is waiting.
//  - Undefined: no gcnt registers; dem_x = (q_x != 0); MAX_GREEN is ignored.
// TESTING (defaults DEB_LEN=4, DEPART_CYCLES=8, QW=4)
//  1. Reset, then det_a=1 held -> q_a 0->1 exactly 6 edges after the first sampling edge;
//     dem_a=1 from then on; a held det_a gives no further increments.
//  2. Glitches on det_b of 1-3 cycles separated by low periods -> q_b stays 0, dem_b=0.
//  3. q_a=3 with l_a=0 held -> q_a=2,1,0 at 8-cycle intervals; dem_a drops with q_a=0.
//     With l_a=2 set mid-interval: q_a frozen and timer cleared.
//  4. Arrival on the same edge as a departure -> q_a unchanged.
//     16 arrivals from q_a=0 -> q_a=15 and ovf_a=1. A further departure -> q_a=14, ovf_a
//     still 1.
//  5. Assert reset with q_a=5, ovf_a=1 and det_a held high -> all outputs 0 next edge;
//     after release q_a=1, 6 edges later.
//  6. With TDS_MAXGREEN_EN: l_a=0 held, q_a=15, q_b=1 -> dem_a=0 once gcnt_a reaches 64.
//     Repeat with q_b=0 -> dem_a stays 1.

Source files
------------

// File: rtl/traffic_demand_sensor.sv
// Vehicle-demand front end: debounces road A/B loop detectors, queues and retires vehicles,
// and produces the controller's demand inputs. Optional green-hold cut: TDS_MAXGREEN_EN.
module tds_road #(
    parameter int DEB_LEN       = 4,
    parameter int DEPART_CYCLES = 8,
    parameter int QW            = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          det_i,
    input  logic [1:0]    l_i,
    output logic [QW-1:0] q_o,
    output logic          ovf_o
);
    localparam int DW = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;
    localparam int TW = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;
    localparam logic [QW-1:0] QMAX = '1;

    logic          s1_q, s2_q, deb_q;
    logic [DW-1:0] dcnt_q;
    logic [TW-1:0] tcnt_q;
    logic [QW-1:0] q_q, q_d;
    logic          ovf_q, ovf_d;
    logic          deb_done, arrival, timer_run, departure;

    // The arrival is taken from the accepting edge itself so q moves together with deb.
    assign deb_done  = (s2_q != deb_q) && (dcnt_q == DW'(DEB_LEN - 1));
    assign arrival   = deb_done && s2_q;
    assign timer_run = (l_i == 2'd0) && (q_q != '0);
    assign departure = timer_run && (tcnt_q == TW'(DEPART_CYCLES - 1));

    always_comb begin
        q_d   = q_q;
        ovf_d = ovf_q;
        if (arrival && !departure) begin
            if (q_q == QMAX) ovf_d = 1'b1;
            else             q_d   = q_q + 1'b1;
        end else if (departure && !arrival) begin
            q_d = q_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            deb_q  <= 1'b0;
            dcnt_q <= '0;
            tcnt_q <= '0;
            q_q    <= '0;
            ovf_q  <= 1'b0;
        end else begin
            s1_q <= det_i;
            s2_q <= s1_q;
            if (s2_q == deb_q) begin
                dcnt_q <= '0;
            end else if (deb_done) begin
                deb_q  <= s2_q;
                dcnt_q <= '0;
            end else begin
                dcnt_q <= dcnt_q + 1'b1;
            end
            if (!timer_run || departure) tcnt_q <= '0;
            else                         tcnt_q <= tcnt_q + 1'b1;
            q_q   <= q_d;
            ovf_q <= ovf_d;
        end
    end

    assign q_o   = q_q;
    assign ovf_o = ovf_q;
endmodule

module traffic_demand_sensor #(
    parameter int DEB_LEN       = 4,
    parameter int DEPART_CYCLES = 8,
    parameter int QW            = 4,
    parameter int MAX_GREEN     = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          det_a_i,
    input  logic          det_b_i,
    input  logic [1:0]    l_a_i,
    input  logic [1:0]    l_b_i,
    output logic          dem_a_o,
    output logic          dem_b_o,
    output logic [QW-1:0] q_a_o,
    output logic [QW-1:0] q_b_o,
    output logic          ovf_a_o,
    output logic          ovf_b_o
);
    tds_road #(.DEB_LEN(DEB_LEN), .DEPART_CYCLES(DEPART_CYCLES), .QW(QW)) u_road_a (
        .clk(clk), .reset(reset), .det_i(det_a_i), .l_i(l_a_i), .q_o(q_a_o), .ovf_o(ovf_a_o)
    );
    tds_road #(.DEB_LEN(DEB_LEN), .DEPART_CYCLES(DEPART_CYCLES), .QW(QW)) u_road_b (
        .clk(clk), .reset(reset), .det_i(det_b_i), .l_i(l_b_i), .q_o(q_b_o), .ovf_o(ovf_b_o)
    );

`ifdef TDS_MAXGREEN_EN
    localparam int GW = $clog2(MAX_GREEN + 1);
    logic [GW-1:0] gcnt_a_q, gcnt_b_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            gcnt_a_q <= '0;
            gcnt_b_q <= '0;
        end else begin
            if (l_a_i != 2'd0)                  gcnt_a_q <= '0;
            else if (gcnt_a_q != GW'(MAX_GREEN)) gcnt_a_q <= gcnt_a_q + 1'b1;
            if (l_b_i != 2'd0)                  gcnt_b_q <= '0;
            else if (gcnt_b_q != GW'(MAX_GREEN)) gcnt_b_q <= gcnt_b_q + 1'b1;
        end
    end

    // A long green is only cut when the other road actually has someone waiting.
    assign dem_a_o = (q_a_o != '0) && !((gcnt_a_q == GW'(MAX_GREEN)) && (q_b_o != '0));
    assign dem_b_o = (q_b_o != '0) && !((gcnt_b_q == GW'(MAX_GREEN)) && (q_a_o != '0));
`else
    assign dem_a_o = (q_a_o != '0);
    assign dem_b_o = (q_b_o != '0);
`endif
endmodule

// File: tb/tb_traffic_demand_sensor.sv
// Self-checking bench for traffic_demand_sensor: directed scenarios plus randomized traffic
// compared every cycle against a window-based behavioural model.
module tb_traffic_demand_sensor;
    localparam int DEB_LEN       = 4;
    localparam int DEPART_CYCLES = 8;
    localparam int QW            = 4;
    localparam int MAX_GREEN     = 64;
    localparam int QMAX          = (1 << QW) - 1;
    localparam int VW            = 2 * QW + 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          det_a = 1'b0, det_b = 1'b0;
    logic [1:0]    l_a = 2'd2, l_b = 2'd2;
    logic          dem_a, dem_b, ovf_a, ovf_b;
    logic [QW-1:0] q_a, q_b;
    logic [VW-1:0] dut_vec;

    int checks = 0;
    int failures = 0;

    traffic_demand_sensor #(
        .DEB_LEN(DEB_LEN), .DEPART_CYCLES(DEPART_CYCLES), .QW(QW), .MAX_GREEN(MAX_GREEN)
    ) dut (
        .clk(clk), .reset(reset), .det_a_i(det_a), .det_b_i(det_b), .l_a_i(l_a), .l_b_i(l_b),
        .dem_a_o(dem_a), .dem_b_o(dem_b), .q_a_o(q_a), .q_b_o(q_b), .ovf_a_o(ovf_a), .ovf_b_o(ovf_b)
    );

    always #5 clk = ~clk;
    assign dut_vec = {dem_a, dem_b, q_a, q_b, ovf_a, ovf_b};

    // Model: a detector change is accepted once the last DEB_LEN synchronized samples all
    // disagree with the accepted level; a vehicle leaves after every DEPART_CYCLES green
    // cycles spent with a non-empty queue.
    bit md1[2], md2[2], mdeb[2];
    bit mhist[2][DEB_LEN];
    bit movf[2];
    int mq[2], mrun[2], mg[2];

    task automatic model_step();
        bit det[2];
        int lc[2];
        det[0] = det_a; det[1] = det_b;
        lc[0] = int'(l_a); lc[1] = int'(l_b);
        if (reset) begin
            for (int r = 0; r < 2; r++) begin
                md1[r] = 0; md2[r] = 0; mdeb[r] = 0; movf[r] = 0;
                mq[r] = 0; mrun[r] = 0; mg[r] = 0;
                for (int k = 0; k < DEB_LEN; k++) mhist[r][k] = 0;
            end
            return;
        end
        for (int r = 0; r < 2; r++) begin
            bit all_diff, arr, dep;
            for (int k = DEB_LEN - 1; k > 0; k--) mhist[r][k] = mhist[r][k-1];
            mhist[r][0] = md2[r];
            all_diff = 1;
            for (int k = 0; k < DEB_LEN; k++) if (mhist[r][k] == mdeb[r]) all_diff = 0;
            arr = 0;
            if (all_diff) begin
                arr = !mdeb[r];
                mdeb[r] = !mdeb[r];
            end
            dep = 0;
            if (lc[r] == 0 && mq[r] > 0) begin
                mrun[r]++;
                if (mrun[r] == DEPART_CYCLES) begin
                    dep = 1;
                    mrun[r] = 0;
                end
            end else begin
                mrun[r] = 0;
            end
            if (arr && !dep) begin
                if (mq[r] == QMAX) movf[r] = 1;
                else               mq[r]++;
            end else if (dep && !arr) begin
                mq[r]--;
            end
            mg[r] = (lc[r] == 0) ? ((mg[r] < MAX_GREEN) ? mg[r] + 1 : MAX_GREEN) : 0;
            md2[r] = md1[r];
            md1[r] = det[r];
        end
    endtask

    function automatic logic [VW-1:0] exp_vec();
        logic da, db;
        da = (mq[0] != 0);
        db = (mq[1] != 0);
`ifdef TDS_MAXGREEN_EN
        if (mg[0] == MAX_GREEN && mq[1] != 0) da = 0;
        if (mg[1] == MAX_GREEN && mq[0] != 0) db = 0;
`endif
        return {da, db, QW'(mq[0]), QW'(mq[1]), movf[0], movf[1]};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic pulse(input bit on_a, input bit on_b);
        for (int k = 0; k < 12; k++) begin
            det_a = on_a && (k < 5);
            det_b = on_b && (k < 5);
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1; det_a = 0; det_b = 0; l_a = 2; l_b = 2;
        repeat (3) tick();
        if (dut_vec !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %h want 0", dut_vec);
        end
        checks++;
        if (dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL reset_model: got %h want %h", dut_vec, exp_vec());
        end
        checks++;
        reset = 0;
    endtask

    task automatic test_arrival();
        det_a = 1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (q_a !== QW'(i == 6 ? 1 : 0) || dem_a !== (i == 6)) begin
                failures++;
                $display("FAIL arrival_latency edge %0d: q_a=%0d dem_a=%b want q_a=%0d", i, q_a, dem_a, (i == 6));
            end
            checks++;
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (q_a !== 1 || dem_a !== 1 || dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL arrival_held: got %h want %h (q_a=1)", dut_vec, exp_vec());
            end
            checks++;
        end
        det_a = 0;
        repeat (8) tick();
    endtask

    task automatic test_glitch();
        for (int p = 0; p < 8; p++) begin
            int hi, lo;
            hi = $urandom_range(1, 3);
            lo = $urandom_range(2, 6);
            for (int k = 0; k < hi + lo; k++) begin
                det_b = (k < hi);
                tick();
                if (q_b !== 0 || dem_b !== 0 || dut_vec !== exp_vec()) begin
                    failures++;
                    $display("FAIL glitch_b: q_b=%0d dem_b=%b got %h want %h", q_b, dem_b, dut_vec, exp_vec());
                end
                checks++;
            end
        end
        det_b = 0;
        repeat (8) tick();
    endtask

    task automatic test_departure();
        pulse(1, 0);
        pulse(1, 0);
        if (q_a !== 3 || dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL depart_setup: q_a=%0d want 3", q_a);
        end
        checks++;
        l_a = 0;
        for (int i = 1; i <= 24; i++) begin
            tick();
            if (q_a !== QW'(3 - i / DEPART_CYCLES) || dem_a !== (i < 24)) begin
                failures++;
                $display("FAIL depart_drain cycle %0d: q_a=%0d dem_a=%b want %0d", i, q_a, dem_a, 3 - i / DEPART_CYCLES);
            end
            checks++;
        end
        l_a = 2;
        pulse(1, 0);
        pulse(1, 0);
        l_a = 0;
        repeat (5) tick();
        l_a = 2;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (q_a !== 2 || dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL depart_freeze: q_a=%0d want 2", q_a);
            end
            checks++;
        end
        l_a = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (q_a !== QW'(i == 8 ? 1 : 2)) begin
                failures++;
                $display("FAIL depart_timer_cleared cycle %0d: q_a=%0d want %0d", i, q_a, (i == 8) ? 1 : 2);
            end
            checks++;
        end
        l_a = 2;
        tick();
    endtask

    task automatic test_back_to_back();
        int bound;
        l_a = 0;
        tick();
        tick();
        det_a = 1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (q_a !== 1 || dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL same_edge cycle %0d: q_a=%0d want 1", i, q_a);
            end
            checks++;
        end
        l_a = 2;
        det_a = 0;
        repeat (8) tick();
        l_a = 0;
        bound = 0;
        while (mq[0] != 0 && bound < 200) begin
            tick();
            bound++;
        end
        if (bound >= 200 || q_a !== 0) begin
            failures++;
            $display("FAIL drain_timeout: q_a=%0d want 0", q_a);
        end
        checks++;
        l_a = 2;
        tick();
        for (int n = 0; n < 16; n++) pulse(1, 0);
        if (q_a !== QW'(QMAX) || ovf_a !== 1 || dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL overflow: q_a=%0d ovf_a=%b want %0d and 1", q_a, ovf_a, QMAX);
        end
        checks++;
        l_a = 0;
        repeat (DEPART_CYCLES) tick();
        l_a = 2;
        if (q_a !== QW'(QMAX - 1) || ovf_a !== 1) begin
            failures++;
            $display("FAIL overflow_sticky: q_a=%0d ovf_a=%b want %0d and 1", q_a, ovf_a, QMAX - 1);
        end
        checks++;
    endtask

    task automatic test_reset_mid();
        int bound;
        l_a = 0;
        bound = 0;
        while (mq[0] != 5 && bound < 200) begin
            tick();
            bound++;
        end
        l_a = 2;
        if (q_a !== 5 || ovf_a !== 1) begin
            failures++;
            $display("FAIL reset_mid_setup: q_a=%0d ovf_a=%b want 5 and 1", q_a, ovf_a);
        end
        checks++;
        det_a = 1;
        reset = 1;
        tick();
        if (dut_vec !== '0) begin
            failures++;
            $display("FAIL reset_mid_clear: got %h want 0", dut_vec);
        end
        checks++;
        reset = 0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (q_a !== QW'(i == 6 ? 1 : 0) || ovf_a !== 0) begin
                failures++;
                $display("FAIL reset_mid_recount edge %0d: q_a=%0d ovf_a=%b want %0d", i, q_a, ovf_a, (i == 6));
            end
            checks++;
        end
        det_a = 0;
        repeat (8) tick();
    endtask

    task automatic test_random();
        int ha, hb, hla, hlb;
        ha = 1; hb = 1; hla = 1; hlb = 1;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 499) == 0);
            if (--ha == 0) begin det_a = !det_a; ha = $urandom_range(1, 10); end
            if (--hb == 0) begin det_b = !det_b; hb = $urandom_range(1, 10); end
            if (--hla == 0) begin
                l_a = $urandom_range(0, 1) ? 2'd0 : 2'($urandom_range(1, 3));
                hla = $urandom_range(1, 60);
            end
            if (--hlb == 0) begin
                l_b = $urandom_range(0, 1) ? 2'd0 : 2'($urandom_range(1, 3));
                hlb = $urandom_range(1, 60);
            end
            tick();
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL random cycle %0d: got %h want %h", c, dut_vec, exp_vec());
            end
            checks++;
        end
        reset = 0;
    endtask

`ifdef TDS_MAXGREEN_EN
    task automatic test_maxgreen();
        for (int pass = 0; pass < 2; pass++) begin
            reset = 1; det_a = 0; det_b = 0; l_a = 2; l_b = 2;
            tick();
            reset = 0;
            pulse(1, pass == 0);
            for (int n = 1; n < 15; n++) pulse(1, 0);
            l_a = 0;
            for (int i = 1; i <= 70; i++) begin
                tick();
                if (dem_a !== ((pass == 1) || (i < MAX_GREEN)) || dut_vec !== exp_vec()) begin
                    failures++;
                    $display("FAIL maxgreen pass %0d cycle %0d: dem_a=%b got %h want %h", pass, i, dem_a, dut_vec, exp_vec());
                end
                checks++;
            end
            l_a = 2;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_arrival();
        test_glitch();
        test_departure();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef TDS_MAXGREEN_EN
        test_maxgreen();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
